placement_registry: RTL and testbench

- Storage and collision responder for setup-time placements, i.e. nests and sugar patches.
- The setup sequencer writes accepted nest/patch coordinates here, and issues candidate-location queries.
- Answers each query over a valid/ready handshake by scanning every stored slot sequentially, one slot per cycle.
- Also drives the stored nest/patch coordinate arrays to the ant setup logic and the renderer.

---
 rtl/placement_registry_pkg.sv | 25 ++
 rtl/placement_registry_box_overlap.sv | 47 ++++
 rtl/placement_registry.sv | 204 ++++++++++++++++++++
 tb/tb_placement_registry.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/placement_registry_pkg.sv
// Shared definitions for the placement registry: default geometry,
// object kinds and the query FSM encoding.
// Optional feature macro: PLACEMENT_EARLY_EXIT_EN (see placement_registry.sv).
package placement_registry_pkg;

   localparam int X_BITS            = 8;
   localparam int Y_BITS            = 7;
   localparam int NEST_RADIUS       = 6;
   localparam int SUGARPATCH_RADIUS = 4;
   localparam int NEST_NUM          = 4;
   localparam int SUGARPATCH_NUM    = 8;
   localparam int GAP               = 2;

   typedef enum logic {
      KIND_NEST  = 1'b0,
      KIND_PATCH = 1'b1
   } obj_kind_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } registry_state_t;

endpackage

// File: rtl/placement_registry_box_overlap.sv
// Combinational box-overlap test between a candidate centre and one stored
// centre: both per-axis distances must be within the inclusive threshold.
module box_overlap #(
   parameter int X_BITS = placement_registry_pkg::X_BITS,
   parameter int Y_BITS = placement_registry_pkg::Y_BITS
) (
   input  logic [X_BITS-1:0] ax,
   input  logic [Y_BITS-1:0] ay,
   input  logic [X_BITS-1:0] bx,
   input  logic [Y_BITS-1:0] by,
   input  logic [X_BITS:0]   thr,
   output logic              overlap
);
   import placement_registry_pkg::*;

   // Common compare width wide enough for either axis distance and the threshold.
   localparam int CW = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 1;

   // Distance on the x axis, computed one bit wider so it never wraps.
   function automatic logic [X_BITS:0] abs_dx(input logic [X_BITS-1:0] a,
                                              input logic [X_BITS-1:0] b);
      logic signed [X_BITS+1:0] d;
      d = $signed({2'b00, a}) - $signed({2'b00, b});
      return (d < 0) ? (X_BITS+1)'(-d) : (X_BITS+1)'(d);
   endfunction

   // Distance on the y axis, same widening as abs_dx.
   function automatic logic [Y_BITS:0] abs_dy(input logic [Y_BITS-1:0] a,
                                              input logic [Y_BITS-1:0] b);
      logic signed [Y_BITS+1:0] d;
      d = $signed({2'b00, a}) - $signed({2'b00, b});
      return (d < 0) ? (Y_BITS+1)'(-d) : (Y_BITS+1)'(d);
   endfunction

   logic [CW-1:0] dx_w;
   logic [CW-1:0] dy_w;
   logic [CW-1:0] thr_w;

   // Zero-extend everything to a common width and compare inclusively.
   always_comb begin
      dx_w    = CW'(abs_dx(ax, bx));
      dy_w    = CW'(abs_dy(ay, by));
      thr_w   = CW'(thr);
      overlap = (dx_w <= thr_w) && (dy_w <= thr_w);
   end

endmodule

// File: rtl/placement_registry.sv
// Placement registry: stores nest and sugar-patch centres written by the
// setup sequencer and answers candidate collision queries by scanning every
// slot, one per cycle, through a single box_overlap comparator.
// Optional feature macro: PLACEMENT_EARLY_EXIT_EN -- when defined, the scan
// stops on the edge after the first hit instead of running all slots.
module placement_registry #(
   parameter int NEST_NUM     = placement_registry_pkg::NEST_NUM,
   parameter int PATCH_NUM    = placement_registry_pkg::SUGARPATCH_NUM,
   parameter int X_BITS       = placement_registry_pkg::X_BITS,
   parameter int Y_BITS       = placement_registry_pkg::Y_BITS,
   parameter int NEST_RADIUS  = placement_registry_pkg::NEST_RADIUS,
   parameter int PATCH_RADIUS = placement_registry_pkg::SUGARPATCH_RADIUS,
   parameter int GAP          = placement_registry_pkg::GAP,
   localparam int ID_W  = ($clog2(NEST_NUM) > $clog2(PATCH_NUM)) ? $clog2(NEST_NUM) : $clog2(PATCH_NUM),
   localparam int N_TOT = NEST_NUM + PATCH_NUM,
   localparam int IDX_W = $clog2(NEST_NUM + PATCH_NUM)
) (
   input  logic                               setup_clk,
   input  logic                               RESET_SIM,
   input  logic                               wr_en,
   input  logic                               wr_kind,
   input  logic [ID_W-1:0]                    wr_id,
   input  logic [X_BITS-1:0]                  wr_x,
   input  logic [Y_BITS-1:0]                  wr_y,
   input  logic                               q_valid,
   output logic                               q_ready,
   input  logic                               q_kind,
   input  logic [X_BITS-1:0]                  q_x,
   input  logic [Y_BITS-1:0]                  q_y,
   output logic                               r_valid,
   input  logic                               r_ready,
   output logic                               r_collision,
   output logic [IDX_W-1:0]                   r_index,
   output logic [NEST_NUM-1:0][X_BITS-1:0]    nests_X,
   output logic [NEST_NUM-1:0][Y_BITS-1:0]    nests_Y,
   output logic [PATCH_NUM-1:0][X_BITS-1:0]   patches_X,
   output logic [PATCH_NUM-1:0][Y_BITS-1:0]   patches_Y,
   output logic [NEST_NUM-1:0]                nest_valid,
   output logic [PATCH_NUM-1:0]               patch_valid
);
   import placement_registry_pkg::*;

   // Half-extent of an object of the given kind.
   function automatic int radius_of(input obj_kind_t k);
      return (k == KIND_PATCH) ? PATCH_RADIUS : NEST_RADIUS;
   endfunction

   registry_state_t    state;
   logic [IDX_W-1:0]   idx;
   obj_kind_t          cand_kind;
   logic [X_BITS-1:0]  cand_x;
   logic [Y_BITS-1:0]  cand_y;
   logic               found;
   logic [IDX_W-1:0]   hit_idx;

   logic [X_BITS-1:0]  slot_x;
   logic [Y_BITS-1:0]  slot_y;
   logic               slot_vld;
   obj_kind_t          slot_kind;
   logic [X_BITS:0]    thr;
   logic               overlap;
   logic               slot_hit;
   logic               last_slot;

   // Storage update: a write lands in any state; out-of-range ids are dropped.
   always_ff @(posedge setup_clk) begin
      if (RESET_SIM) begin
         nests_X     <= '0;
         nests_Y     <= '0;
         patches_X   <= '0;
         patches_Y   <= '0;
         nest_valid  <= '0;
         patch_valid <= '0;
      end else if (wr_en) begin
         if (wr_kind == KIND_NEST) begin
            for (int i = 0; i < NEST_NUM; i++) begin
               if (wr_id == ID_W'(i)) begin
                  nests_X[i]    <= wr_x;
                  nests_Y[i]    <= wr_y;
                  nest_valid[i] <= 1'b1;
               end
            end
         end else begin
            for (int j = 0; j < PATCH_NUM; j++) begin
               if (wr_id == ID_W'(j)) begin
                  patches_X[j]   <= wr_x;
                  patches_Y[j]   <= wr_y;
                  patch_valid[j] <= 1'b1;
               end
            end
         end
      end
   end

   // Select the slot addressed by the scan index from the live storage.
   always_comb begin
      slot_x    = '0;
      slot_y    = '0;
      slot_vld  = 1'b0;
      slot_kind = KIND_NEST;
      for (int s = 0; s < NEST_NUM; s++) begin
         if (idx == IDX_W'(s)) begin
            slot_x    = nests_X[s];
            slot_y    = nests_Y[s];
            slot_vld  = nest_valid[s];
            slot_kind = KIND_NEST;
         end
      end
      for (int j = 0; j < PATCH_NUM; j++) begin
         if (idx == IDX_W'(NEST_NUM + j)) begin
            slot_x    = patches_X[j];
            slot_y    = patches_Y[j];
            slot_vld  = patch_valid[j];
            slot_kind = KIND_PATCH;
         end
      end
   end

   // Clearance threshold for the current candidate/slot kind pair.
   always_comb begin
      thr = (X_BITS+1)'(radius_of(cand_kind)) + (X_BITS+1)'(radius_of(slot_kind))
          + (X_BITS+1)'(GAP);
   end

   box_overlap #(
      .X_BITS (X_BITS),
      .Y_BITS (Y_BITS)
   ) u_box_overlap (
      .ax      (cand_x),
      .ay      (cand_y),
      .bx      (slot_x),
      .by      (slot_y),
      .thr     (thr),
      .overlap (overlap)
   );

   // Hit qualification: empty slots never collide.
   always_comb begin
      slot_hit  = slot_vld && overlap;
      last_slot = (idx == IDX_W'(N_TOT - 1));
   end

   // Query FSM: accept in IDLE, scan every slot, hold the response until taken.
   always_ff @(posedge setup_clk) begin
      if (RESET_SIM) begin
         state     <= IDLE;
         idx       <= '0;
         cand_kind <= KIND_NEST;
         cand_x    <= '0;
         cand_y    <= '0;
         found     <= 1'b0;
         hit_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (q_valid) begin
                  cand_kind <= obj_kind_t'(q_kind);
                  cand_x    <= q_x;
                  cand_y    <= q_y;
                  idx       <= '0;
                  found     <= 1'b0;
                  hit_idx   <= '0;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               // Only the first hit is kept so the lowest slot is reported.
               if (slot_hit && !found) begin
                  found   <= 1'b1;
                  hit_idx <= idx;
               end
`ifdef PLACEMENT_EARLY_EXIT_EN
               if (slot_hit || last_slot) begin
                  state <= RESP;
               end else begin
                  idx <= idx + 1'b1;
               end
`else
               if (last_slot) begin
                  state <= RESP;
               end else begin
                  idx <= idx + 1'b1;
               end
`endif
            end
            RESP: begin
               if (r_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake outputs; the result is only presented while a response is pending.
   always_comb begin
      q_ready     = (state == IDLE);
      r_valid     = (state == RESP);
      r_collision = r_valid && found;
      r_index     = r_collision ? hit_idx : '0;
   end

endmodule

// File: tb/tb_placement_registry.sv
// Directed bench for placement_registry: writes, collision queries, latency,
// response hold under back-pressure and reset in the middle of a scan.
module tb_placement_registry;

   logic                  setup_clk;
   logic                  RESET_SIM;
   logic                  wr_en;
   logic                  wr_kind;
   logic [2:0]            wr_id;
   logic [7:0]            wr_x;
   logic [6:0]            wr_y;
   logic                  q_valid;
   logic                  q_ready;
   logic                  q_kind;
   logic [7:0]            q_x;
   logic [6:0]            q_y;
   logic                  r_valid;
   logic                  r_ready;
   logic                  r_collision;
   logic [3:0]            r_index;
   logic [3:0][7:0]       nests_X;
   logic [3:0][6:0]       nests_Y;
   logic [7:0][7:0]       patches_X;
   logic [7:0][6:0]       patches_Y;
   logic [3:0]            nest_valid;
   logic [7:0]            patch_valid;

   int passed = 0;
   int total  = 0;

`ifdef PLACEMENT_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   placement_registry dut (
      .setup_clk   (setup_clk),
      .RESET_SIM   (RESET_SIM),
      .wr_en       (wr_en),
      .wr_kind     (wr_kind),
      .wr_id       (wr_id),
      .wr_x        (wr_x),
      .wr_y        (wr_y),
      .q_valid     (q_valid),
      .q_ready     (q_ready),
      .q_kind      (q_kind),
      .q_x         (q_x),
      .q_y         (q_y),
      .r_valid     (r_valid),
      .r_ready     (r_ready),
      .r_collision (r_collision),
      .r_index     (r_index),
      .nests_X     (nests_X),
      .nests_Y     (nests_Y),
      .patches_X   (patches_X),
      .patches_Y   (patches_Y),
      .nest_valid  (nest_valid),
      .patch_valid (patch_valid)
   );

   initial setup_clk = 1'b0;
   always #5 setup_clk = ~setup_clk;

   task automatic step();
      @(posedge setup_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int exp_lat(input bit hit, input int k);
      return (EARLY && hit) ? k + 1 : 12;
   endfunction

   task automatic write_obj(input logic kind, input logic [2:0] id,
                            input logic [7:0] x, input logic [6:0] y);
      wr_en = 1'b1; wr_kind = kind; wr_id = id; wr_x = x; wr_y = y;
      step();
      wr_en = 1'b0;
   endtask

   task automatic run_query(input string tag, input logic kind,
                            input logic [7:0] x, input logic [6:0] y,
                            input bit exp_col, input int exp_idx);
      int lat;
      check({tag, "_q_ready_idle"}, 32'(q_ready), 32'd1);
      q_valid = 1'b1; q_kind = kind; q_x = x; q_y = y;
      step();
      q_valid = 1'b0;
      lat = 0;
      while (r_valid !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat(exp_col, exp_idx)));
      check({tag, "_collision"}, 32'(r_collision), 32'(exp_col));
      check({tag, "_index"}, 32'(r_index), exp_col ? 32'(exp_idx) : 32'd0);
      check({tag, "_q_ready_busy"}, 32'(q_ready), 32'd0);
      r_ready = 1'b1;
      step();
      r_ready = 1'b0;
      check({tag, "_r_valid_drop"}, 32'(r_valid), 32'd0);
   endtask

   initial begin
      int lat;
      RESET_SIM = 1'b1;
      wr_en = 1'b0; wr_kind = 1'b0; wr_id = '0; wr_x = '0; wr_y = '0;
      q_valid = 1'b0; q_kind = 1'b0; q_x = '0; q_y = '0; r_ready = 1'b0;
      step();
      step();
      RESET_SIM = 1'b0;

      // Reset state
      check("rst_q_ready", 32'(q_ready), 32'd1);
      check("rst_r_valid", 32'(r_valid), 32'd0);
      check("rst_r_collision", 32'(r_collision), 32'd0);
      check("rst_r_index", 32'(r_index), 32'd0);
      check("rst_nest_valid", 32'(nest_valid), 32'd0);
      check("rst_patch_valid", 32'(patch_valid), 32'd0);

      // Empty registry: full scan, no collision
      run_query("empty", 1'b0, 8'd50, 7'd40, 1'b0, 0);

      // Nest 0 at (50,40)
      write_obj(1'b0, 3'd0, 8'd50, 7'd40);
      check("wr_nest_valid", 32'(nest_valid), 32'h1);
      check("wr_nests_X0", 32'(nests_X[0]), 32'd50);
      check("wr_nests_Y0", 32'(nests_Y[0]), 32'd40);

      // Nest vs nest: T=14 inclusive boundary
      run_query("nn_edge", 1'b0, 8'd64, 7'd40, 1'b1, 0);
      run_query("nn_out", 1'b0, 8'd65, 7'd40, 1'b0, 0);
      // Patch vs nest: T=12
      run_query("pn_edge", 1'b1, 8'd62, 7'd40, 1'b1, 0);
      run_query("pn_out", 1'b1, 8'd63, 7'd40, 1'b0, 0);
      // Candidate left of the nest: distance must not wrap
      run_query("pn_left", 1'b1, 8'd38, 7'd40, 1'b1, 0);
      run_query("pn_left_out", 1'b1, 8'd37, 7'd40, 1'b0, 0);

      // Patch 2 at (100,100), slot 6
      write_obj(1'b1, 3'd2, 8'd100, 7'd100);
      check("wr_patch_valid", 32'(patch_valid), 32'h4);
      check("wr_patches_X2", 32'(patches_X[2]), 32'd100);
      check("wr_patches_Y2", 32'(patches_Y[2]), 32'd100);
      run_query("pp_hit", 1'b1, 8'd104, 7'd108, 1'b1, 6);
      run_query("pp_dy_out", 1'b1, 8'd104, 7'd111, 1'b0, 0);

      // Nest 3 at the same spot: lowest hitting slot wins
      write_obj(1'b0, 3'd3, 8'd100, 7'd100);
      check("wr_nest_valid2", 32'(nest_valid), 32'h9);
      run_query("lowest", 1'b1, 8'd104, 7'd108, 1'b1, 3);

      // Back-pressure: response held while r_ready is low
      q_valid = 1'b1; q_kind = 1'b0; q_x = 8'd50; q_y = 7'd40;
      step();
      q_valid = 1'b0;
      lat = 0;
      while (r_valid !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
      check("hold_latency", 32'(lat), 32'(exp_lat(1'b1, 0)));
      for (int c = 0; c < 5; c++) begin
         check("hold_r_valid", 32'(r_valid), 32'd1);
         check("hold_collision", 32'(r_collision), 32'd1);
         check("hold_index", 32'(r_index), 32'd0);
         check("hold_q_ready", 32'(q_ready), 32'd0);
         step();
      end
      r_ready = 1'b1;
      step();
      r_ready = 1'b0;
      check("hold_release", 32'(q_ready), 32'd1);

      // Reset in the middle of a scan of a non-hitting candidate
      q_valid = 1'b1; q_kind = 1'b0; q_x = 8'd200; q_y = 7'd5;
      step();
      q_valid = 1'b0;
      step();
      step();
      RESET_SIM = 1'b1;
      step();
      RESET_SIM = 1'b0;
      check("midrst_r_valid", 32'(r_valid), 32'd0);
      check("midrst_q_ready", 32'(q_ready), 32'd1);
      check("midrst_nest_valid", 32'(nest_valid), 32'd0);
      check("midrst_patch_valid", 32'(patch_valid), 32'd0);
      check("midrst_nests_X", 32'(nests_X), 32'd0);

      // Out-of-range nest id is dropped; in-range patch id 7 lands
      write_obj(1'b0, 3'd5, 8'd9, 7'd9);
      check("oor_nest_valid", 32'(nest_valid), 32'd0);
      check("oor_nests_X", 32'(nests_X), 32'd0);
      write_obj(1'b1, 3'd7, 8'd9, 7'd9);
      check("p7_patch_valid", 32'(patch_valid), 32'h80);
      run_query("p7_hit", 1'b0, 8'd0, 7'd0, 1'b1, 11);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
